ah_pl2ddr_tx_arbiter: RTL

//   Shares one AXI burst-write master between NUM_CH pl2ddr command FSMs. Grants in_transfer_en to one channel at a

---
 rtl/ah_pl2ddr_tx_arbiter_pkg.sv | 31 +++
 rtl/ah_pl2ddr_rr_pick.sv | 42 ++++
 rtl/ah_pl2ddr_tx_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ah_pl2ddr_tx_arbiter_pkg.sv
// ah_pl2ddr_tx_arbiter_pkg
//   Shared types and constants for the pl2ddr transmit arbiter: arbiter state
//   encodings, status bit positions, field widths and a small index helper.
package ah_pl2ddr_tx_arbiter_pkg;

    localparam int ID_W   = 3;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 9;
    localparam int NUM_W  = 11;
    localparam int STAT_W = 8;

    // Sticky status bit positions.
    localparam int STAT_TIMEOUT = 0;
    localparam int STAT_PROTO   = 1;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_ACTIVE = 2'd1,
        ST_ACTIVE      = 2'd2,
        ST_RELEASE     = 2'd3
    } arb_state_e;

    // (idx + 1) mod n, for the round-robin pointer.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx, input int n);
        int nxt;
        nxt = int'(idx) + 1;
        if (nxt >= n) nxt = 0;
        return ID_W'(nxt);
    endfunction

endpackage

// File: rtl/ah_pl2ddr_rr_pick.sv
// ah_pl2ddr_rr_pick
//   Combinational winner selection among eligible channels.
//   Ports:
//     eligible    in  NUM_CH  requesting and enabled channels
//     rr_ptr      in  3       round-robin start index
//     fixed_mode  in  1       1 = lowest eligible index wins, 0 = round-robin
//     winner      out 3       selected channel index (0 when none)
//     valid       out 1       at least one channel eligible
module ah_pl2ddr_rr_pick
    import ah_pl2ddr_tx_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [ID_W-1:0]   rr_ptr,
    input  logic              fixed_mode,
    output logic [ID_W-1:0]   winner,
    output logic              valid
);

    int start;
    int idx;

    // Scan NUM_CH slots starting at the pointer (or 0 in fixed mode), wrapping;
    // the first eligible slot wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        start  = fixed_mode ? 0 : int'(rr_ptr);
        idx    = 0;
        if (start >= NUM_CH) start = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = start + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!valid && eligible[idx]) begin
                valid  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ah_pl2ddr_tx_arbiter.sv
// ah_pl2ddr_tx_arbiter
//   Shares one AXI burst-write master between NUM_CH pl2ddr command FSMs.
//   One channel at a time gets in_transfer_en; its burst descriptor and
//   tx_init are forwarded to the master, tx_done/axi_error are routed back.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     ch_req/ch_transfer_en    per-channel request / one-hot grant
//     ch_transfer_active       per-channel FSM busy indication
//     ch_ddr_addr/len/num      packed per-channel burst descriptors
//     ch_tx_init/ch_tx_done    per-channel start / completion pulses
//     ch_axi_error             per-channel AXI error level
//     m_*                      shared AXI master interface
//     in_enable_mask           channels allowed to win
//     in_priority_mode         0 = round-robin, 1 = fixed lowest index
//     in_status_clr            clears sticky status
//     out_grant_id/busy/status/grant_count  observability
module ah_pl2ddr_tx_arbiter
    import ah_pl2ddr_tx_arbiter_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int GRANT_TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_req,
    output logic [NUM_CH-1:0]        ch_transfer_en,
    input  logic [NUM_CH-1:0]        ch_transfer_active,
    input  logic [NUM_CH*ADDR_W-1:0] ch_ddr_addr,
    input  logic [NUM_CH*LEN_W-1:0]  ch_burst_len,
    input  logic [NUM_CH*NUM_W-1:0]  ch_burst_num,
    input  logic [NUM_CH-1:0]        ch_tx_init,
    output logic [NUM_CH-1:0]        ch_tx_done,
    output logic [NUM_CH-1:0]        ch_axi_error,
    output logic [ADDR_W-1:0]        m_ddr_addr,
    output logic [LEN_W-1:0]         m_burst_len,
    output logic [NUM_W-1:0]         m_burst_num,
    output logic                     m_tx_init,
    input  logic                     m_tx_done,
    input  logic                     m_axi_error,
    input  logic [NUM_CH-1:0]        in_enable_mask,
    input  logic                     in_priority_mode,
    input  logic                     in_status_clr,
    output logic [ID_W-1:0]          out_grant_id,
    output logic                     out_busy,
    output logic [STAT_W-1:0]        out_status,
    output logic [31:0]              out_grant_count
);

    localparam int TMR_W = $clog2(GRANT_TIMEOUT + 2);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         status_q, status_d;
    logic [31:0]        count_q, count_d;
    logic               outstanding_q, outstanding_d;
    logic               drain_q, drain_d;      // active already fell with a burst in flight
    logic               timeout_q, timeout_d;  // current release came from the timeout path
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic [LEN_W-1:0]   m_len_q, m_len_d;
    logic [NUM_W-1:0]   m_num_q, m_num_d;
    logic               m_init_q, m_init_d;

    logic [NUM_CH-1:0]  gnt_oh;
    logic [NUM_CH-1:0]  en_raw;
    logic [NUM_CH-1:0]  done_raw;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic [NUM_W-1:0]   sel_num;
    logic               active_g;
    logic               init_g;
    logic               accept;
    logic [ID_W-1:0]    pick_id;
    logic               pick_valid;

    ah_pl2ddr_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .eligible   (ch_req & in_enable_mask),
        .rr_ptr     (rr_ptr_q),
        .fixed_mode (in_priority_mode),
        .winner     (pick_id),
        .valid      (pick_valid)
    );

    // Granted-channel decode and descriptor mux.
    always_comb begin
        gnt_oh   = '0;
        sel_addr = '0;
        sel_len  = '0;
        sel_num  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gnt_oh[c] = (grant_id_q == ID_W'(c));
            if (gnt_oh[c]) begin
                sel_addr = ch_ddr_addr[c*ADDR_W +: ADDR_W];
                sel_len  = ch_burst_len[c*LEN_W +: LEN_W];
                sel_num  = ch_burst_num[c*NUM_W +: NUM_W];
            end
        end
        active_g = |(ch_transfer_active & gnt_oh);
        init_g   = |(ch_tx_init & gnt_oh);
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        timer_d       = timer_q;
        status_d      = in_status_clr ? 2'b00 : status_q;  // later sets override the clear
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drain_d       = drain_q;
        timeout_d     = timeout_q;
        m_addr_d      = m_addr_q;
        m_len_d       = m_len_q;
        m_num_d       = m_num_q;
        m_init_d      = 1'b0;
        en_raw        = '0;
        done_raw      = '0;
        accept        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_id_d    = pick_id;
                    timer_d       = '0;
                    outstanding_d = 1'b0;
                    drain_d       = 1'b0;
                    timeout_d     = 1'b0;
                    state_d       = ST_WAIT_ACTIVE;
                end
            end
            ST_WAIT_ACTIVE: begin
                en_raw = gnt_oh;
                if (active_g) begin
                    state_d = ST_ACTIVE;
                end else if (timer_q == TMR_W'(GRANT_TIMEOUT)) begin
                    status_d[STAT_TIMEOUT] = 1'b1;
                    timeout_d              = 1'b1;
                    state_d                = ST_RELEASE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_ACTIVE: begin
                // Enable follows active so the FSM never re-arms on a stale enable.
                en_raw = gnt_oh & {NUM_CH{active_g}};
                if (m_tx_done) begin
                    done_raw      = gnt_oh;
                    outstanding_d = 1'b0;
                end
                accept = init_g && !outstanding_q;
                if (init_g && outstanding_q) status_d[STAT_PROTO] = 1'b1;
                if (accept) begin
                    m_addr_d      = sel_addr;
                    m_len_d       = sel_len;
                    m_num_d       = sel_num;
                    m_init_d      = 1'b1;
                    outstanding_d = 1'b1;
                end
                if (!active_g) begin
                    if (!outstanding_q && !accept) begin
                        state_d = ST_RELEASE;
                    end else begin
                        // Channel gave up with a burst in flight: flag once, then
                        // hold the master until it reports completion.
                        if (!drain_q) status_d[STAT_PROTO] = 1'b1;
                        drain_d = 1'b1;
                        if (m_tx_done && outstanding_q) state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                rr_ptr_d = wrap_inc(grant_id_q, NUM_CH);
                if (!timeout_q && count_q != '1) count_d = count_q + 32'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            timer_q       <= '0;
            status_q      <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            drain_q       <= 1'b0;
            timeout_q     <= 1'b0;
            m_addr_q      <= '0;
            m_len_q       <= '0;
            m_num_q       <= '0;
            m_init_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            timer_q       <= timer_d;
            status_q      <= status_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drain_q       <= drain_d;
            timeout_q     <= timeout_d;
            m_addr_q      <= m_addr_d;
            m_len_q       <= m_len_d;
            m_num_q       <= m_num_d;
            m_init_q      <= m_init_d;
        end
    end

    // Reset gates the grant and the pending start pulse in the same cycle,
    // so a reset never leaks a burst start into a master being reset with us.
    assign ch_transfer_en  = rst ? '0 : en_raw;
    assign m_tx_init       = m_init_q & ~rst;
    assign ch_tx_done      = done_raw;
    assign ch_axi_error    = m_axi_error ? gnt_oh : '0;
    assign m_ddr_addr      = m_addr_q;
    assign m_burst_len     = m_len_q;
    assign m_burst_num     = m_num_q;
    assign out_grant_id    = grant_id_q;
    assign out_busy        = (state_q != ST_IDLE);
    assign out_status      = {{(STAT_W-2){1'b0}}, status_q};
    assign out_grant_count = count_q;

endmodule
